// File: rtl/audio_mix_sequencer.sv
// Sequenced stereo mixer: snapshots all sources once per sample period, then
// accumulates one source per clock and saturates to 9-bit offset-binary DAC words.
// Optional mute ramp: define AUDIO_MIX_SEQ_MUTE_RAMP_EN.
//
// state | meaning
// IDLE  | waiting for the period tick
// LATCH | snapshot sources/pan/gain, clear accumulators
// ACC   | add one slot per cycle into acc_l/acc_r
// SAT   | shift, saturate (or mute) and register the DAC words
module audio_mix_sequencer #(
  parameter int NSRC  = 8,
  parameter int DIV   = 256,
  parameter int SHIFT = 2
) (
  input  logic                 clk,
  input  logic                 Reset,
  input  logic [10*NSRC-1:0]   src_bus,
  input  logic [2*NSRC-1:0]    src_pan,
  input  logic [2*NSRC-1:0]    src_gain,
  input  logic                 mute,
  input  logic                 clip_clr,
  output logic [8:0]           left_out,
  output logic [8:0]           right_out,
  output logic                 sample_stb,
  output logic                 clip_l,
  output logic                 clip_r
);

  localparam int CW = $clog2(DIV);
  localparam int SW = $clog2(NSRC);
  localparam int AW = 10 + SW;
  localparam logic [SW-1:0] LAST_SLOT = SW'(NSRC - 1);
  localparam logic [8:0]    MID       = 9'h100;

  typedef enum logic [1:0] {IDLE, LATCH, ACC, SAT} state_t;

  state_t         state, state_nxt;
  logic [CW-1:0]  cnt;
  logic           tick;
  logic [SW-1:0]  slot;
  logic           do_latch, do_acc, do_sat, last_slot;

  logic [9:0]     sh_src  [NSRC];
  logic [1:0]     sh_pan  [NSRC];
  logic [1:0]     sh_gain [NSRC];
  logic [AW-1:0]  acc_l, acc_r;
  logic [9:0]     v;
  logic [AW-1:0]  s_l, s_r;
  logic           ovf_l, ovf_r;
  logic [8:0]     sat_l, sat_r, mix_l, mix_r;

  assign tick      = (cnt == CW'(DIV - 1));
  assign last_slot = (slot == LAST_SLOT);

  always_ff @(posedge clk) begin
    if (Reset)     cnt <= '0;
    else if (tick) cnt <= '0;
    else           cnt <= cnt + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (tick) state_nxt = LATCH;
      LATCH:   state_nxt = ACC;
      ACC:     if (last_slot) state_nxt = SAT;
      SAT:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    do_latch = (state == LATCH);
    do_acc   = (state == ACC);
    do_sat   = (state == SAT);
  end

  always_comb begin
    v = sh_src[slot] >> sh_gain[slot];
  end

  function automatic logic [8:0] ramp_mid(input logic [8:0] p);
    if (p < MID)      return p + 9'd1;
    else if (p > MID) return p - 9'd1;
    else              return p;
  endfunction

  always_comb begin
    s_l   = acc_l >> SHIFT;
    s_r   = acc_r >> SHIFT;
    ovf_l = (s_l > AW'(511));
    ovf_r = (s_r > AW'(511));
    sat_l = ovf_l ? 9'd511 : s_l[8:0];
    sat_r = ovf_r ? 9'd511 : s_r[8:0];
`ifdef AUDIO_MIX_SEQ_MUTE_RAMP_EN
    mix_l = mute ? ramp_mid(left_out)  : sat_l;
    mix_r = mute ? ramp_mid(right_out) : sat_r;
`else
    mix_l = mute ? MID : sat_l;
    mix_r = mute ? MID : sat_r;
`endif
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      slot       <= '0;
      acc_l      <= '0;
      acc_r      <= '0;
      left_out   <= MID;
      right_out  <= MID;
      sample_stb <= 1'b0;
      clip_l     <= 1'b0;
      clip_r     <= 1'b0;
      for (int i = 0; i < NSRC; i++) begin
        sh_src[i]  <= '0;
        sh_pan[i]  <= '0;
        sh_gain[i] <= '0;
      end
    end else begin
      sample_stb <= do_sat;
      if (do_latch) begin
        for (int i = 0; i < NSRC; i++) begin
          sh_src[i]  <= src_bus[10*i +: 10];
          sh_pan[i]  <= src_pan[2*i +: 2];
          sh_gain[i] <= src_gain[2*i +: 2];
        end
        acc_l <= '0;
        acc_r <= '0;
        slot  <= '0;
      end
      if (do_acc) begin
        if (sh_pan[slot][1]) acc_l <= acc_l + AW'(v);
        if (sh_pan[slot][0]) acc_r <= acc_r + AW'(v);
        slot <= slot + SW'(1);
      end
      if (do_sat) begin
        left_out  <= mix_l;
        right_out <= mix_r;
      end
      // a clip set in the same cycle as clip_clr takes priority
      clip_l <= (do_sat & ovf_l) | (clip_l & ~clip_clr);
      clip_r <= (do_sat & ovf_r) | (clip_r & ~clip_clr);
    end
  end

endmodule
